// File: rtl/vdp18_pkg.sv
`default_nettype none
// ============================================================================
//  Package : vdp18_pkg
//  Brief   : Shared constants and types for the VDP clock generation chain.
//  Rev     : 1.0  initial release
// ============================================================================
package vdp18_pkg;

  // Number of phases in the downstream divide-by-12 clock divider.
  localparam int VDP_PHASES = 12;

  // Default accumulator / increment width of the master-enable NCO.
  localparam int VDP_NCO_ACC_W = 32;

  // Phase index 0..VDP_PHASES-1.
  typedef logic [3:0] vdp_phase_t;

  // Advance a phase index, wrapping after the last divider phase.
  function automatic vdp_phase_t vdp_phase_next(input vdp_phase_t p);
    if (p == vdp_phase_t'(VDP_PHASES - 1)) begin
      return '0;
    end
    return p + 4'd1;
  endfunction

endpackage : vdp18_pkg
`default_nettype wire

// File: rtl/vdp18_clk_en_nco.sv
`default_nettype none
// ============================================================================
//  Module  : vdp18_clk_en_nco
//  Brief   : Fractional phase-accumulator NCO generating the 10.7 MHz master
//            clock enable, with a ready/valid increment load that takes
//            effect on an enable boundary, a 12-phase enable counter and a
//            synchronous realign input.
//  Rev     : 1.0  initial release
// ============================================================================
module vdp18_clk_en_nco
  import vdp18_pkg::*;
#(
  parameter int               ACC_W     = VDP_NCO_ACC_W,
  parameter logic [ACC_W-1:0] INC_RESET = 32'd922_440_000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             run_i,
  input  logic             sync_i,
  input  logic [ACC_W-1:0] inc_i,
  input  logic             inc_valid_i,
  output logic             inc_ready_o,
  output logic             inc_err_o,
  output logic             clk_en_10m7_o,
  output logic [3:0]       phase_o
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc_q;
  logic [ACC_W-1:0] pend_q;
  logic             pend_v;
  logic             en_q;
  logic             err_q;
  vdp_phase_t       phase_q;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic             accept;
  logic             apply;

  // One extra bit on the sum holds the wrap-around carry.
  assign sum    = {1'b0, acc} + {1'b0, inc_q};

  // A carry only counts when an add actually happens: sync suppresses it.
  assign carry  = run_i & ~sync_i & sum[ACC_W];

  // The load slot is free exactly when nothing is pending.
  assign inc_ready_o = ~pend_v;
  assign accept      = inc_valid_i & inc_ready_o;

  // Swap in a pending rate on an enable boundary, or at any time while
  // frozen (with a zero rate, a frozen NCO is the only way to change it).
  assign apply  = pend_v & (carry | ~run_i);

  assign clk_en_10m7_o = en_q;
  assign inc_err_o     = err_q;
  assign phase_o       = phase_q;

  // Accumulator and registered enable: add every cycle while running.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc  <= '0;
      en_q <= 1'b0;
    end else if (sync_i) begin
      acc  <= '0;
      en_q <= 1'b0;
    end else if (run_i) begin
      acc  <= sum[ACC_W-1:0];
      en_q <= sum[ACC_W];
    end else begin
      en_q <= 1'b0;
    end
  end

  // Increment register and load handshake; MSB-set loads are rejected
  // because they would allow back-to-back enables.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      inc_q  <= INC_RESET;
      pend_q <= '0;
      pend_v <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (apply) begin
        inc_q  <= pend_q;
        pend_v <= 1'b0;
      end else if (accept) begin
        if (inc_i[ACC_W-1]) begin
          err_q <= 1'b1;
        end else begin
          pend_q <= inc_i;
          pend_v <= 1'b1;
        end
      end
    end
  end

  // Phase counter: counts emitted enables modulo 12, cleared by sync.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      phase_q <= '0;
    end else if (sync_i) begin
      phase_q <= '0;
    end else if (en_q) begin
      phase_q <= vdp_phase_next(phase_q);
    end
  end

endmodule : vdp18_clk_en_nco
`default_nettype wire
